// File: rtl/acc_pkg.sv
// Shared definitions for the FP16 reduction tree / streaming accumulator.
//   FP16_W, FP16_ZERO : binary16 width and +0 encoding
//   acc_state_t       : accumulator FSM state encoding
//   fp16_add()        : combinational binary16 add, round-to-nearest-even
package acc_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_t;

  // Mantissas carry 3 extra low bits (guard, round, sticky) through alignment
  // and normalisation. Any NaN input yields the canonical quiet NaN 7E00.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  ex, ey, d;
    logic [13:0] mx, my;
    logic        sticky, rup;
    logic [14:0] s;
    logic [5:0]  e;
    logic [11:0] m;
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
      return 16'h7E00;
    if (a[14:10] == 5'h1F && b[14:10] == 5'h1F)
      return (a[15] == b[15]) ? a : 16'h7E00;
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    // x is the operand of larger magnitude; it supplies sign and exponent
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
    my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
    d  = ex - ey;
    sticky = 1'b0;
    for (int i = 0; i < 14; i++)
      if (5'(i) < d) sticky = sticky | my[i];
    my    = (d > 5'd13) ? 14'd0 : (my >> d);
    my[0] = my[0] | sticky;
    s = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (s == 15'd0) return {x[15] & y[15], 15'd0};
    e = {1'b0, ex};
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      for (int i = 0; i < 13; i++)
        if (!s[13] && e > 6'd1) begin
          s = s << 1;
          e = e - 6'd1;
        end
    end
    rup = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[13:3]} + {11'd0, rup};
    if (m[11]) begin
      m = m >> 1;
      e = e + 6'd1;
    end
    if (e >= 6'd31) return {x[15], 5'h1F, 10'd0};
    // hidden bit clear means the result stayed subnormal
    return {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
  endfunction

endpackage

// File: rtl/acc_tag_fifo.sv
// Synchronous FIFO of 1-bit "last" tags that travel alongside beats in the tree.
//   clk, rst_n     : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_din  : write strobe and tag
//   i_pop, o_dout  : read strobe and head tag
//   o_full/o_empty : occupancy flags
module acc_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fp16_adder.sv
// One-stage pipelined FP16 adder with valid/ready on both sides (latency 1).
//   clk, rst_n       : clock, synchronous active-low reset
//   i_valid/o_ready  : operand handshake, i_a/i_b operands
//   o_valid/i_ready  : result handshake, o_sum result
module fp16_adder
  import acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [FP16_W-1:0] i_a,
  input  logic [FP16_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [FP16_W-1:0] o_sum
);

  logic              r_valid;
  logic [FP16_W-1:0] r_sum;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_sum   = r_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= FP16_ZERO;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_sum   <= fp16_add(i_a, i_b);
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_tree_stream.sv
// N_IN-to-1 FP16 adder tree feeding a serial accumulator that sums tree results
// until a beat tagged in_last closes the group.
//   in_valid/in_ready/in_vec/in_last  : input beat handshake, lanes, group-close flag
//   out_valid/out_ready               : group result handshake
//   out_sum/out_count                 : FP16 group sum, beats in group (saturating)
//
// state    | meaning
// EMPTY    | no partial sum; next tree result seeds the accumulator
// HOLD     | partial sum held; waiting for the next tree result
// BUSY     | accumulator adder computing acc + tree result
// OUT      | group result presented until downstream takes it
module acc_tree_stream
  import acc_pkg::*;
#(
  parameter int N_IN      = 16,
  parameter int TAG_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*FP16_W-1:0] in_vec,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP16_W-1:0]      out_sum,
  output logic [CNT_W-1:0]       out_count
);

  // Heap-indexed tree: node 1 is the root, node n joins 2n and 2n+1,
  // indices N_IN..2*N_IN-1 are the input lanes.
  logic              w_v    [1:2*N_IN-1];
  logic              w_r    [1:2*N_IN-1];
  logic [FP16_W-1:0] w_d    [1:2*N_IN-1];
  logic              w_nrdy [1:N_IN-1];

  logic              w_accept, w_tree_rdy, w_pop, w_acc_take;
  logic              w_tag, w_tag_full, w_tag_empty;
  logic              w_aadd_ivld, w_aadd_rdy, w_aadd_vld;
  logic [FP16_W-1:0] w_aadd_sum;

  acc_state_t        r_state, w_state_nx;
  logic [FP16_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;

  for (genvar i = 0; i < N_IN; i++) begin : g_leaf
    assign w_v[N_IN+i] = w_accept;
    assign w_d[N_IN+i] = in_vec[i*FP16_W +: FP16_W];
  end

  for (genvar n = 1; n < N_IN; n++) begin : g_node
    fp16_adder u_add (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_v[2*n] & w_v[2*n+1]),
      .o_ready (w_nrdy[n]),
      .i_a     (w_d[2*n]),
      .i_b     (w_d[2*n+1]),
      .o_valid (w_v[n]),
      .i_ready (w_r[n]),
      .o_sum   (w_d[n])
    );
    // siblings share one ready so they always pop together
    assign w_r[2*n]   = w_nrdy[n];
    assign w_r[2*n+1] = w_nrdy[n];
  end

  always_comb begin
    w_tree_rdy = 1'b1;
    for (int i = 0; i < N_IN; i++) w_tree_rdy = w_tree_rdy & w_r[N_IN+i];
  end

  assign in_ready = rst_n && w_tree_rdy && !w_tag_full;
  assign w_accept = in_valid && in_ready;
  assign w_r[1]   = w_acc_take && !w_tag_empty;
  assign w_pop    = w_v[1] && w_r[1];

  acc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_din   (in_last),
    .i_pop   (w_pop),
    .o_dout  (w_tag),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  assign w_aadd_ivld = (r_state == ST_HOLD) && w_pop;

  fp16_adder u_acc_add (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_aadd_ivld),
    .o_ready (w_aadd_rdy),
    .i_a     (r_acc),
    .i_b     (w_d[1]),
    .o_valid (w_aadd_vld),
    .i_ready (r_state == ST_BUSY),
    .o_sum   (w_aadd_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc_take = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_acc_take = 1'b1;
        if (w_pop) w_state_nx = w_tag ? ST_OUT : ST_HOLD;
      end
      ST_HOLD: begin
        w_acc_take = w_aadd_rdy;
        if (w_pop) w_state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_aadd_vld) w_state_nx = r_last ? ST_OUT : ST_HOLD;
      end
      ST_OUT: begin
        if (out_ready) w_state_nx = ST_EMPTY;
      end
      default: w_state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= FP16_ZERO;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_pop) begin
          r_acc <= w_d[1];
          r_cnt <= CNT_W'(1);
        end
        ST_HOLD: if (w_pop) begin
          r_last <= w_tag;
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_BUSY: if (w_aadd_vld) r_acc <= w_aadd_sum;
        ST_OUT:  if (out_ready)  r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == ST_OUT);
  assign out_sum   = out_valid ? r_acc : FP16_ZERO;
  assign out_count = out_valid ? r_cnt : '0;

endmodule
